// File: rtl/leftshift_multicycle.sv
// leftshift_multicycle: sequential 32-bit logical left shifter.
// Applies one binary shift stage (1, 2, 4, 8, 16) per clock, so every
// operation takes exactly 5 cycles regardless of the shift distance.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset
//   A        - operand, captured on an accepted start
//   shiftAmt - shift distance 0..31, captured on an accepted start
//   start    - request, accepted only while busy is low
//   res      - last completed result (registered)
//   busy     - high while an operation is in flight (registered)
//   done     - one-cycle pulse when res first shows a new result (registered)
module leftshift_multicycle (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [4:0]  shiftAmt,
    input  logic        start,
    output logic [31:0] res,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(4);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   work_q,  work_d;
    logic [AMT_W-1:0]    amt_q,   amt_d;
    logic [DATA_W-1:0]   res_q,   res_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic [DATA_W-1:0]   stage_val;

    // Result of applying the current stage to the work register.
    always_comb begin
        stage_val = work_q;
        case (cnt_q)
            CNT_W'(0): if (amt_q[0]) stage_val = work_q << 1;
            CNT_W'(1): if (amt_q[1]) stage_val = work_q << 2;
            CNT_W'(2): if (amt_q[2]) stage_val = work_q << 4;
            CNT_W'(3): if (amt_q[3]) stage_val = work_q << 8;
            CNT_W'(4): if (amt_q[4]) stage_val = work_q << 16;
            default:   stage_val = work_q;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        amt_d   = amt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = A;
                    amt_d   = shiftAmt;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = stage_val;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STAGE) begin
                    // Final stage goes straight to res; start is not
                    // considered this cycle, so back-to-back accepts at E6.
                    res_d   = stage_val;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            amt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign res  = res_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_leftshift_multicycle.sv
// Testbench for leftshift_multicycle: directed vectors plus a random sweep;
// expected results are queued at issue and checked by a monitor on done.
module tb_leftshift_multicycle;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [4:0]  shiftAmt;
    logic        start;
    logic [31:0] res;
    logic        busy;
    logic        done;

    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    leftshift_multicycle dut (
        .clock    (clock),
        .reset    (reset),
        .A        (A),
        .shiftAmt (shiftAmt),
        .start    (start),
        .res      (res),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, checks handshake rules
    // and that res holds steady between completions.
    task automatic monitor();
        logic [31:0] prev_res;
        logic        prev_done;
        logic        skip;
        prev_res  = '0;
        prev_done = 1'b0;
        skip      = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                skip      = 1'b1;
                prev_done = 1'b0;
                prev_res  = res;
            end else begin
                if (done) begin
                    chk("done_with_busy", 32'(busy), 32'(0));
                    chk("done_consecutive", 32'(prev_done), 32'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual res=%h required no pulse at %0t", res, $time);
                    end else begin
                        chk("result", res, exp_q.pop_front());
                    end
                end else if (!skip) begin
                    chk("res_stable", res, prev_res);
                end
                skip      = 1'b0;
                prev_done = done;
                prev_res  = res;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual busy=1 required busy=0 at %0t", $time);
        end
    endtask

    // Drive one start cycle; optionally queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [4:0] sh, input bit push);
        start    = 1'b1;
        A        = a;
        shiftAmt = sh;
        if (push) exp_q.push_back(a << sh);
        tick();
        start    = 1'b0;
        A        = $urandom;
        shiftAmt = 5'($urandom_range(0, 31));
    endtask

    task automatic driver();
        reset    = 1'b1;
        start    = 1'b0;
        A        = '0;
        shiftAmt = '0;
        repeat (3) tick();
        chk("reset_res", res, 32'h0);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        reset = 1'b0;
        tick();

        // 1 << 31 with per-cycle busy/done timing
        issue(32'h0000_0001, 5'd31, 1'b1);
        chk("busy_after_e0", 32'(busy), 32'(1));
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("busy_in_run", 32'(busy), 32'(1));
            chk("done_in_run", 32'(done), 32'(0));
        end
        tick();
        chk("done_after_e5", 32'(done), 32'(1));
        chk("busy_after_e5", 32'(busy), 32'(0));
        chk("res_after_e5", res, 32'h8000_0000);
        tick();
        chk("done_after_e6", 32'(done), 32'(0));

        // Zero shift passes operand through
        wait_idle();
        issue(32'hDEAD_BEEF, 5'd0, 1'b1);
        wait_idle();
        tick();

        // Operands wiggling during RUN must not matter
        issue(32'hFFFF_FFFF, 5'd13, 1'b1);
        for (int i = 0; i < 4; i++) begin
            A        = $urandom;
            shiftAmt = 5'($urandom_range(0, 31));
            tick();
        end
        wait_idle();
        tick();

        // Start while busy is ignored
        issue(32'h0F0F_0F0F, 5'd3, 1'b1);
        tick();
        issue(32'h0000_0001, 5'd1, 1'b0);
        wait_idle();
        repeat (8) tick();

        // Reset in the middle of an operation
        issue(32'h1234_5678, 5'd4, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("midreset_res", res, 32'h0);
        chk("midreset_busy", 32'(busy), 32'(0));
        chk("midreset_done", 32'(done), 32'(0));
        reset = 1'b0;
        repeat (10) tick();

        // Start held high: completions at E5, E11, E17
        start    = 1'b1;
        A        = 32'h0000_0001;
        shiftAmt = 5'd8;
        repeat (3) exp_q.push_back(32'h0000_0100);
        for (int e = 0; e <= 18; e++) begin
            tick();
            chk("held_start_done", 32'(done), 32'((e == 5 || e == 11 || e == 17) ? 1 : 0));
            if (e == 12) start = 1'b0;
        end
        wait_idle();

        // Random sweep, issued back to back
        for (int n = 0; n < 1000; n++) begin
            wait_idle();
            issue(32'($urandom), 5'($urandom_range(0, 31)), 1'b1);
        end
        wait_idle();
        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        clock  = 1'b0;
        reset  = 1'b1;
        checks = 0;
        errors = 0;
        fork
            monitor();
            driver();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
